ws2812b_chain: RTL and testbench
================================

# ws2812b_chain

Frame-level controller for a chain of WS2812B LEDs on the softcore memory bus. Holds a pixel buffer of NUM_LEDS 24-bit colours, written and read by the CPU. On a start command it serialises the whole buffer onto a single `din` line, then emits the latch (reset) gap. It replaces per-pixel CPU polling: the CPU fills the buffer, writes START and polls STATUS.

## Interface
- `ADDR`, 32'h0000_0000, base address of the 512-byte register window (ADDR..ADDR+0x1FF).
- `CLK_FREQ`, 12e6, clock frequency in Hz; all pulse widths derive from it.
- `NUM_LEDS`, 8, LEDs in chain; legal range 1..64.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `mem_valid` in 1: bus request.
- `mem_addr` in 32: byte address.
- `mem_wstrb` in 4: byte write strobes; all-zero means read.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: read data. Valid only while `mem_ready`=1, 0 otherwise.
- `mem_ready` out 1: one-cycle acknowledge.
- `din` out 1: serial data to the first LED.

## Operation
- Register map, offsets from ADDR:
  - 0x000 CTRL (W): bit0 START (self-clearing, reads 0); bit1 AUTO (see Configuration).
  - 0x004 STATUS (R): bit0 BUSY; bit1 PENDING; bits[31:16] FRAMES, a 16-bit count of completed frames that wraps 0xFFFF->0.
  - 0x100+4*i PIXEL[i], i < NUM_LEDS (R/W): word 0x00RRGGBB. `mem_wstrb[2:0]` enable bytes individually; `mem_wstrb[3]` is ignored; bits[31:24] read 0.
  - Any other offset in the window reads 0, ignores writes and still acknowledges.
  - Addresses outside the window get no acknowledge.
- Bit timing, each value rounded as $rtoi(x+0.5):
  - T0H = CLK_FREQ·0.40e-6, T0L = ·0.85e-6, T1H = ·0.80e-6, T1L = ·0.45e-6, RES = ·300e-6.
  - At 12 MHz: 5/10/10/5/3600 cycles.
- Pixel wire order: G7..G0, R7..R0, B7..B0, MSB first. Pixel 0 goes first.
- States:
  - IDLE: `din`=0. START (or PENDING) -> LOAD.
  - LOAD: 1 cycle. Copy PIXEL[0] into the shift register, reordered to GRB. -> TxH.
  - TxH: `din`=1 for THx cycles, x = current bit. -> TxL.
  - TxL: `din`=0 for TLx cycles.
    - If bits remain: -> TxH with the next bit.
    - At the last bit of a pixel: the next pixel is loaded from the buffer on the final TxL cycle, so there is no gap between pixels.
    - After pixel NUM_LEDS-1: -> RESET.
  - RESET: `din`=0 for RES cycles, then FRAMES += 1.
    - -> LOAD if PENDING (clear PENDING) or AUTO.
    - -> IDLE otherwise.
- BUSY=1 in every state except IDLE.
- START while BUSY sets PENDING. Repeated STARTs merge into one pending frame.
- Pixel writes are always accepted. A write to the pixel being shifted out takes effect next frame; a write to a later pixel takes effect this frame.

## Timing
- Bus: the request is decoded in cycle n (`mem_valid`=1 and `mem_ready`=0); `mem_ready`=1 and `mem_rdata` are valid in cycle n+1 for exactly one cycle. The master drops `mem_valid` after `mem_ready`.
- START written in cycle n (IDLE): LOAD in n+1; `din` rises in n+2.
- Frame length: 1 + Σbits(THx+TLx) + RES cycles.
- Reset values: `din`=0, `mem_ready`=0, `mem_rdata`=0, state IDLE, BUSY=PENDING=AUTO=0, FRAMES=0. Pixel buffer contents are preserved.
- Reset mid-frame: `din`=0 from the next cycle, and no partial-frame completion is counted.
- START and pixel write in the same cycle: impossible, since the bus carries one request per transaction.
- START in the RESET state's final cycle: sets PENDING, and the next frame follows immediately.

## Configuration
- `WS2812B_CHAIN_AUTO_EN`:
  - Defined: CTRL bit1 AUTO is writable and readable at CTRL. With AUTO=1 the block restarts LOAD immediately after each RESET, refreshing continuously. Clearing AUTO finishes the current frame, then goes to IDLE.
  - Undefined: AUTO is hardwired to 0, writes are ignored, CTRL reads 0.

## Test plan
- Reset, then read STATUS -> `mem_rdata`=0, `din`=0, `mem_ready` pulses once per request.
- NUM_LEDS=2, CLK_FREQ=12e6; PIXEL[0]=0x00FF0000 and PIXEL[1]=0x000000AA; START -> `din` shows 8×'0', 8×'1', 8×'0', then 16×'0', then 10101010.
  - Each '1' = 10 high + 5 low cycles; each '0' = 5 high + 10 low.
  - Followed by 3600 low cycles; then BUSY=0 and FRAMES=1.
- Byte write: PIXEL[0]=0x00123456, then write 0x00AB0000 with wstrb=4'b0100 -> readback 0x00AB3456. Write to offset 0x010 -> ready pulses, read 0.
- START mid-frame, twice -> PENDING=1; exactly one extra frame follows with no IDLE gap; FRAMES=2; BUSY=0 afterwards.
- `reset` asserted during bit 5 of pixel 0 -> `din`=0 on the next cycle, STATUS=0, PIXEL contents unchanged.
- With the macro, AUTO=1 and START -> FRAMES counts 1,2,3 with back-to-back frames; clear AUTO -> stops after the current frame. Without the macro, CTRL reads 0 and one frame runs.

Source files
------------

// File: rtl/ws2812b_chain_if.sv
// Memory-bus bundle between the softcore and the WS2812B chain controller.
`timescale 1ns/1ps
interface ws2812b_chain_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/ws2812b_chain.sv
// WS2812B frame controller: bus-mapped pixel buffer serialised onto din, then the latch gap.
// Define WS2812B_CHAIN_AUTO_EN to enable CTRL.AUTO continuous refresh.
`timescale 1ns/1ps
module ws2812b_chain #(
  parameter logic [31:0] ADDR     = 32'h0000_0000,
  parameter real         CLK_FREQ = 12e6,
  parameter int          NUM_LEDS = 8
) (
  input  logic            clk,
  input  logic            reset,
  ws2812b_chain_if.slave  bus,
  output logic            din
);

  localparam int T0H   = $rtoi(CLK_FREQ * 0.40e-6 + 0.5);
  localparam int T0L   = $rtoi(CLK_FREQ * 0.85e-6 + 0.5);
  localparam int T1H   = $rtoi(CLK_FREQ * 0.80e-6 + 0.5);
  localparam int T1L   = $rtoi(CLK_FREQ * 0.45e-6 + 0.5);
  localparam int RES_C = $rtoi(CLK_FREQ * 300e-6 + 0.5);
  localparam int CW    = $clog2(RES_C + 1);
  localparam int IW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] T0H_M1 = CW'(T0H - 1);
  localparam logic [CW-1:0] T0L_M1 = CW'(T0L - 1);
  localparam logic [CW-1:0] T1H_M1 = CW'(T1H - 1);
  localparam logic [CW-1:0] T1L_M1 = CW'(T1L - 1);
  localparam logic [CW-1:0] RES_M1 = CW'(RES_C - 1);
  localparam logic [IW-1:0] LAST   = IW'(NUM_LEDS - 1);

  // state  | meaning
  // IDLE   | din low, waiting for START / PENDING
  // LOAD   | pixel 0 copied into shift register (GRB)
  // TXH    | high phase of current bit
  // TXL    | low phase; next bit or next pixel loaded on last cycle
  // RES    | latch gap, frame counted on its last cycle
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TXH, S_TXL, S_RES} state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [23:0]   r_sr, w_sr_nxt;
  logic [4:0]    r_bits, w_bits_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic          w_done, w_consume;

  logic [23:0]   r_pix [NUM_LEDS];
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_pending;
  logic [15:0]   r_frames;
  logic          r_din;
  logic          w_auto;

  logic [31:0]   w_off;
  logic          w_hit, w_req, w_wr, w_aligned;
  logic          w_is_ctrl, w_is_stat, w_is_pix;
  logic [IW-1:0] w_pidx;
  logic          w_start;
  logic [31:0]   w_rd;
  logic [IW-1:0] w_ld_idx;
  logic [23:0]   w_ld_pix, w_grb;
  logic          w_busy;
  logic          w_unused;

  assign w_off     = bus.mem_addr - ADDR;
  assign w_hit     = (w_off[31:9] == 23'd0);
  assign w_req     = bus.mem_valid && !r_ready && w_hit;
  assign w_wr      = w_req && (bus.mem_wstrb != 4'b0000);
  assign w_aligned = (w_off[1:0] == 2'b00);
  assign w_is_ctrl = w_aligned && (w_off[8:2] == 7'd0);
  assign w_is_stat = w_aligned && (w_off[8:2] == 7'd1);
  assign w_is_pix  = w_aligned && w_off[8] && ({1'b0, w_off[7:2]} < 7'(NUM_LEDS));
  assign w_pidx    = w_off[IW+1:2];
  assign w_start   = w_wr && w_is_ctrl && bus.mem_wstrb[0] && bus.mem_wdata[0];
  assign w_busy    = (r_state != S_IDLE);
  assign w_unused  = &{1'b0, bus.mem_wdata[31:24], bus.mem_wstrb[3]};

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign din           = r_din;

`ifdef WS2812B_CHAIN_AUTO_EN
  logic r_auto;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto <= 1'b0;
    end else if (w_wr && w_is_ctrl && bus.mem_wstrb[0]) begin
      r_auto <= bus.mem_wdata[1];
    end
  end

  assign w_auto = r_auto;
`else
  assign w_auto = 1'b0;
`endif

  always_comb begin
    w_rd = 32'd0;
    if (w_is_ctrl) begin
      w_rd[1] = w_auto;
    end else if (w_is_stat) begin
      w_rd = {r_frames, 14'd0, r_pending, w_busy};
    end else if (w_is_pix) begin
      w_rd[23:0] = r_pix[w_pidx];
    end
  end

  // Buffer is deliberately outside reset so a reset keeps the picture.
  always_ff @(posedge clk) begin
    if (w_wr && w_is_pix) begin
      if (bus.mem_wstrb[0]) r_pix[w_pidx][7:0]   <= bus.mem_wdata[7:0];
      if (bus.mem_wstrb[1]) r_pix[w_pidx][15:8]  <= bus.mem_wdata[15:8];
      if (bus.mem_wstrb[2]) r_pix[w_pidx][23:16] <= bus.mem_wdata[23:16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_rdata   <= 32'd0;
      r_pending <= 1'b0;
      r_frames  <= 16'd0;
    end else begin
      r_ready <= w_req;
      r_rdata <= w_req ? w_rd : 32'd0;
      if (w_consume) begin
        r_pending <= 1'b0;
      end else if (w_start && w_busy) begin
        r_pending <= 1'b1;
      end
      if (w_done) begin
        r_frames <= r_frames + 16'd1;
      end
    end
  end

  assign w_ld_idx = (r_state == S_TXL) ? r_idx + IW'(1) : '0;
  assign w_ld_pix = r_pix[w_ld_idx];
  assign w_grb    = {w_ld_pix[15:8], w_ld_pix[23:16], w_ld_pix[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= 24'd0;
      r_bits  <= 5'd0;
      r_idx   <= '0;
      r_din   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      r_bits  <= w_bits_nxt;
      r_idx   <= w_idx_nxt;
      r_din   <= (w_nxt == S_TXH);
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_sr_nxt   = r_sr;
    w_bits_nxt = r_bits;
    w_idx_nxt  = r_idx;
    w_done     = 1'b0;
    w_consume  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start || r_pending) begin
          w_nxt     = S_LOAD;
          w_consume = 1'b1;
        end
      end
      S_LOAD: begin
        w_sr_nxt   = w_grb;
        w_idx_nxt  = '0;
        w_bits_nxt = 5'd23;
        w_cnt_nxt  = w_grb[23] ? T1H_M1 : T0H_M1;
        w_nxt      = S_TXH;
      end
      S_TXH: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = r_sr[23] ? T1L_M1 : T0L_M1;
          w_nxt     = S_TXL;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_TXL: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_bits != 5'd0) begin
          w_sr_nxt   = {r_sr[22:0], 1'b0};
          w_bits_nxt = r_bits - 5'd1;
          w_cnt_nxt  = r_sr[22] ? T1H_M1 : T0H_M1;
          w_nxt      = S_TXH;
        end else if (r_idx == LAST) begin
          w_cnt_nxt = RES_M1;
          w_nxt     = S_RES;
        end else begin
          // Next pixel fetched from the live buffer, so later-pixel writes land this frame.
          w_sr_nxt   = w_grb;
          w_idx_nxt  = w_ld_idx;
          w_bits_nxt = 5'd23;
          w_cnt_nxt  = w_grb[23] ? T1H_M1 : T0H_M1;
          w_nxt      = S_TXH;
        end
      end
      S_RES: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_done = 1'b1;
          if (r_pending || w_start || w_auto) begin
            w_consume = 1'b1;
            w_nxt     = S_LOAD;
          end else begin
            w_nxt = S_IDLE;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_chain.sv
// Scoreboard bench for ws2812b_chain (NUM_LEDS=2, 12 MHz): bus responses and din run lengths.
`timescale 1ns/1ps
module tb_ws2812b_chain;
  localparam int T0H = 5, T0L = 10, T1H = 10, T1L = 5, RES = 3600;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din;

  always #5 clk = ~clk;

  ws2812b_chain_if bus_if();

  ws2812b_chain #(.ADDR(32'h0000_0000), .CLK_FREQ(12e6), .NUM_LEDS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .din   (din)
  );

  typedef struct { logic chk; logic [31:0] exp; string nm; } bus_exp_t;
  typedef struct { logic lvl; int len; } run_t;

  bus_exp_t bus_q[$];
  run_t     din_q[$];
  logic     mon_en = 1'b0;
  int       n_chk = 0;
  int       n_pass = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  // bus monitor: pops one expectation per acknowledge, then checks the pulse ends
  initial begin
    bus_exp_t e;
    logic after_ack;
    after_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (after_ack) begin
        check("ack_pulse_end", bus_if.mem_rdata | {31'd0, bus_if.mem_ready}, 32'd0);
        after_ack = 1'b0;
      end
      if (bus_if.mem_ready === 1'b1) begin
        if (bus_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = bus_q.pop_front();
          if (e.chk) check(e.nm, bus_if.mem_rdata, e.exp);
        end
        after_ack = 1'b1;
      end
    end
  end

  // din monitor: each completed constant-level run is compared with the next expected run
  initial begin
    logic prev;
    int   run;
    run_t e;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (din === prev) begin
        run++;
      end else begin
        if (mon_en) begin
          if (din_q.size() == 0) begin
            check("din_unexpected_run", 32'(run), 32'd0);
          end else begin
            e = din_q.pop_front();
            check("din_level", {31'd0, prev}, {31'd0, e.lvl});
            if (e.len != 0) check("din_run_len", 32'(run), 32'(e.len));
          end
        end
        prev = din;
        run  = 1;
      end
    end
  end

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic chk, input logic [31:0] exp, input string nm);
    bus_exp_t e;
    bit got;
    e.chk = chk; e.exp = exp; e.nm = nm;
    bus_q.push_back(e);
    @(posedge clk); #1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = a;
    bus_if.mem_wdata = d;
    bus_if.mem_wstrb = s;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_if.mem_ready === 1'b1) got = 1'b1;
    end
    bus_if.mem_valid = 1'b0;
    bus_if.mem_wstrb = 4'd0;
    if (!got) begin
      check({nm, "_ack_timeout"}, 32'd0, 32'd1);
      void'(bus_q.pop_back());
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_xfer(a, d, s, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus_xfer(a, 32'd0, 4'd0, 1'b1, exp, nm);
  endtask

  task automatic no_ack(input logic [31:0] a, input string nm);
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = a;
    bus_if.mem_wstrb = 4'd0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus_if.mem_ready === 1'b1) cnt++;
    end
    bus_if.mem_valid = 1'b0;
    check(nm, 32'(cnt), 32'd0);
  endtask

  // expected runs for one 2-pixel frame; follow=1 means the next frame starts right after RES
  task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1, input logic follow);
    logic [23:0] px [2];
    logic [23:0] grb;
    run_t r;
    px[0] = p0;
    px[1] = p1;
    for (int p = 0; p < 2; p++) begin
      grb = {px[p][15:8], px[p][23:16], px[p][7:0]};
      for (int b = 23; b >= 0; b--) begin
        r.lvl = 1'b1;
        r.len = grb[b] ? T1H : T0H;
        din_q.push_back(r);
        r.lvl = 1'b0;
        r.len = grb[b] ? T1L : T0L;
        if (p == 1 && b == 0) r.len = follow ? r.len + RES + 1 : 0;
        din_q.push_back(r);
      end
    end
  endtask

  task automatic wait_q(input int n, input int budget, input string nm);
    int i;
    i = 0;
    while (din_q.size() > n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(nm, 32'(din_q.size()), 32'(n));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    run_t lead;
    lead.lvl = 1'b0;
    lead.len = 0;
    bus_if.mem_valid = 1'b0;
    bus_if.mem_addr  = 32'd0;
    bus_if.mem_wstrb = 4'd0;
    bus_if.mem_wdata = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_din", {31'd0, din}, 32'd0);
    check("reset_ready", {31'd0, bus_if.mem_ready}, 32'd0);
    check("reset_rdata", bus_if.mem_rdata, 32'd0);
    reset = 1'b0;
    din_q.push_back(lead);
    mon_en = 1'b1;

    rd(32'h004, 32'h0000_0000, "status_after_reset");
    rd(32'h000, 32'h0000_0000, "ctrl_after_reset");
    wr(32'h100, 32'h0012_3456, 4'hF);
    rd(32'h100, 32'h0012_3456, "pix0_full_write");
    wr(32'h100, 32'h00AB_0000, 4'b0100);
    rd(32'h100, 32'h00AB_3456, "pix0_byte2_write");
    wr(32'h100, 32'hFFFF_FFFF, 4'b1000);
    rd(32'h100, 32'h00AB_3456, "pix0_strb3_ignored");
    wr(32'h104, 32'h0000_0000, 4'hF);
    wr(32'h104, 32'h00FF_FF77, 4'b0001);
    rd(32'h104, 32'h0000_0077, "pix1_byte0_write");
    wr(32'h010, 32'hFFFF_FFFF, 4'hF);
    rd(32'h010, 32'h0000_0000, "unmapped_0x010");
    rd(32'h108, 32'h0000_0000, "pix_beyond_num_leds");
    no_ack(32'h0000_0200, "no_ack_0x200");
    no_ack(32'hFFFF_FFFC, "no_ack_below_base");

    // single frame from IDLE
    wr(32'h100, 32'h00FF_0000, 4'hF);
    wr(32'h104, 32'h0000_00AA, 4'hF);
    push_frame(24'hFF0000, 24'h0000AA, 1'b0);
    wr(32'h000, 32'h0000_0001, 4'hF);
    check("load_cycle_din_low", {31'd0, din}, 32'd0);
    @(posedge clk); #1;
    check("din_rises_n_plus_2", {31'd0, din}, 32'd1);
    wait_q(1, 6000, "frame1_bits_done");
    repeat (3590) @(posedge clk);
    rd(32'h004, 32'h0000_0001, "frame1_still_busy_in_res");
    repeat (40) @(posedge clk);
    rd(32'h004, 32'h0001_0000, "frame1_done");

    // START twice mid-frame, pixel writes during pixel 0
    push_frame(24'hFF0000, 24'h000055, 1'b1);
    push_frame(24'h000000, 24'h000055, 1'b0);
    wr(32'h000, 32'h0000_0001, 4'hF);
    repeat (50) @(posedge clk);
    wr(32'h104, 32'h0000_0055, 4'hF);
    wr(32'h100, 32'h0000_0000, 4'hF);
    wr(32'h000, 32'h0000_0001, 4'hF);
    rd(32'h004, 32'h0001_0003, "pending_set");
    wr(32'h000, 32'h0000_0001, 4'hF);
    rd(32'h004, 32'h0001_0003, "pending_merged");
    wait_q(1, 12000, "pending_frames_bits_done");
    repeat (3590) @(posedge clk);
    rd(32'h004, 32'h0002_0001, "second_frame_in_res");
    repeat (40) @(posedge clk);
    rd(32'h004, 32'h0003_0000, "pending_frames_done");

    // reset during bit 5 of pixel 0
    mon_en = 1'b0;
    wr(32'h000, 32'h0000_0001, 4'hF);
    rd(32'h004, 32'h0003_0001, "busy_before_reset");
    repeat (78) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midframe_reset_din", {31'd0, din}, 32'd0);
    reset = 1'b0;
    rd(32'h004, 32'h0000_0000, "status_after_midframe_reset");
    rd(32'h100, 32'h0000_0000, "pix0_kept");
    rd(32'h104, 32'h0000_0055, "pix1_kept");
    repeat (5000) @(posedge clk);
    rd(32'h004, 32'h0000_0000, "no_partial_frame_counted");

    din_q.delete();
    din_q.push_back(lead);
    mon_en = 1'b1;
`ifdef WS2812B_CHAIN_AUTO_EN
    push_frame(24'h000000, 24'h000055, 1'b1);
    push_frame(24'h000000, 24'h000055, 1'b1);
    push_frame(24'h000000, 24'h000055, 1'b0);
    wr(32'h000, 32'h0000_0003, 4'hF);
    rd(32'h000, 32'h0000_0002, "ctrl_auto_readback");
    wait_q(96, 15000, "auto_two_frames");
    rd(32'h004, 32'h0002_0001, "auto_frames_2");
    wr(32'h000, 32'h0000_0000, 4'hF);
    wait_q(1, 6000, "auto_last_frame_bits");
    repeat (3590) @(posedge clk);
    rd(32'h004, 32'h0002_0001, "auto_last_frame_in_res");
    repeat (40) @(posedge clk);
    rd(32'h004, 32'h0003_0000, "auto_stopped");
`else
    push_frame(24'h000000, 24'h000055, 1'b0);
    wr(32'h000, 32'h0000_0003, 4'hF);
    rd(32'h000, 32'h0000_0000, "ctrl_no_auto_reads_0");
    wait_q(1, 6000, "single_frame_bits");
    repeat (3590) @(posedge clk);
    rd(32'h004, 32'h0000_0001, "single_frame_in_res");
    repeat (40) @(posedge clk);
    rd(32'h004, 32'h0001_0000, "single_frame_only");
`endif

    repeat (5) @(posedge clk);
    check("bus_scoreboard_drained", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
